// File: rtl/fifo_pkg.sv
`default_nettype none
// =============================================================================
// Module      : fifo_pkg
// Description : Pointer types and Gray/binary conversions shared by both FIFO
//               pointer controllers.
// Revision    : 1.0  initial release
// =============================================================================
package fifo_pkg;

   localparam int c_addr_width = 3;
   localparam int c_wide_w     = 32;

   typedef logic [c_addr_width:0] ptr_t;
   typedef logic [c_wide_w-1:0]   ptr_wide_t;

   // Conversions run at a fixed wide width so any pointer width can use them
   // after zero extension; leading zeros leave the low bits unaffected.
   function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
      ptr_wide_t b;
      b[c_wide_w-1] = g[c_wide_w-1];
      for (int i = c_wide_w - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_gray_ptr.sv
`default_nettype none
// =============================================================================
// Module      : fifo_gray_ptr
// Description : Registered binary + Gray pointer with increment enable.
// Revision    : 1.0  initial release
// =============================================================================
module fifo_gray_ptr
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_inc,
   output logic [ADDR_WIDTH:0]   o_bin,
   output logic [ADDR_WIDTH:0]   o_bin_next,
   output logic [ADDR_WIDTH:0]   o_gray,
   output logic [ADDR_WIDTH:0]   o_gray_next
);

   logic [ADDR_WIDTH:0] r_bin;
   logic [ADDR_WIDTH:0] r_gray;
   logic [ADDR_WIDTH:0] w_bin_next;
   logic [ADDR_WIDTH:0] w_gray_next;
   ptr_wide_t           w_gray_wide;
   logic                w_unused_gray_hi;

   assign w_bin_next       = r_bin + {{ADDR_WIDTH{1'b0}}, i_inc};
   assign w_gray_wide      = bin2gray(ptr_wide_t'(w_bin_next));
   assign w_gray_next      = w_gray_wide[ADDR_WIDTH:0];
   assign w_unused_gray_hi = ^w_gray_wide[c_wide_w-1:ADDR_WIDTH+1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bin  <= '0;
         r_gray <= '0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
      end
   end

   assign o_bin       = r_bin;
   assign o_bin_next  = w_bin_next;
   assign o_gray      = r_gray;
   assign o_gray_next = w_gray_next;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : fifo_rd_ctrl
// Description : Async FIFO read-side controller: pointers, empty/level flags
//               and a registered first-word-fall-through output stage.
// Revision    : 1.0  initial release
// =============================================================================
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 3,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  i_rclk,
   input  logic                  i_rrst_n,
   input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
   output logic [ADDR_WIDTH-1:0] o_raddr,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic [ADDR_WIDTH:0]   o_rptr,
   output logic                  o_rempty,
   output logic                  o_raempty,
   output logic [ADDR_WIDTH:0]   o_rlevel,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rvalid,
   input  logic                  i_rready
);

   localparam logic [ADDR_WIDTH:0] c_aempty_thresh = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   logic                  r_rempty;
   logic                  r_raempty;
   logic [ADDR_WIDTH:0]   r_rlevel;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rvalid;

   logic                  w_pop;
   logic [ADDR_WIDTH:0]   w_rbin;
   logic [ADDR_WIDTH:0]   w_rbin_next;
   logic [ADDR_WIDTH:0]   w_rgray_next;
   ptr_wide_t             w_wbin_wide;
   logic [ADDR_WIDTH:0]   w_wbin;
   logic [ADDR_WIDTH:0]   w_level_next;
   logic                  w_unused_wbin_hi;
   logic                  w_unused_rbin_msb;

   // Refill the output stage whenever it is empty or being drained this cycle.
   assign w_pop = ~r_rempty & (~r_rvalid | i_rready);

   fifo_gray_ptr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rptr (
      .i_clk       (i_rclk),
      .i_rst_n     (i_rrst_n),
      .i_inc       (w_pop),
      .o_bin       (w_rbin),
      .o_bin_next  (w_rbin_next),
      .o_gray      (o_rptr),
      .o_gray_next (w_rgray_next)
   );

   assign o_raddr           = w_rbin[ADDR_WIDTH-1:0];
   assign w_unused_rbin_msb = w_rbin[ADDR_WIDTH];

   // Modulo subtraction absorbs the pointer wrap; a full memory yields 2**ADDR_WIDTH.
   assign w_wbin_wide      = gray2bin(ptr_wide_t'(i_rq2_wptr));
   assign w_wbin           = w_wbin_wide[ADDR_WIDTH:0];
   assign w_unused_wbin_hi = ^w_wbin_wide[c_wide_w-1:ADDR_WIDTH+1];
   assign w_level_next     = w_wbin - w_rbin_next;

   always_ff @(posedge i_rclk or negedge i_rrst_n) begin
      if (!i_rrst_n) begin
         r_rempty  <= 1'b1;
         r_raempty <= 1'b1;
         r_rlevel  <= '0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_rempty  <= (w_rgray_next == i_rq2_wptr);
         r_rlevel  <= w_level_next;
         r_raempty <= (w_level_next <= c_aempty_thresh);
         if (w_pop) begin
            r_rdata  <= i_rdata;
            r_rvalid <= 1'b1;
         end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign o_rempty  = r_rempty;
   assign o_raempty = r_raempty;
   assign o_rlevel  = r_rlevel;
   assign o_rdata   = r_rdata;
   assign o_rvalid  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Directed self-checking bench for fifo_rd_ctrl with a behavioural
//               memory and write pointer.
// Revision    : 1.0  initial release
// =============================================================================
module tb_fifo_rd_ctrl;
   import fifo_pkg::*;

   logic       i_rclk = 1'b0;
   logic       i_rrst_n;
   logic [3:0] i_rq2_wptr;
   logic [2:0] o_raddr;
   logic [7:0] i_rdata;
   logic [3:0] o_rptr;
   logic       o_rempty;
   logic       o_raempty;
   logic [3:0] o_rlevel;
   logic [7:0] o_rdata;
   logic       o_rvalid;
   logic       i_rready;

   logic [7:0] mem [8];
   logic [7:0] exp_q [$];
   ptr_t       wbin;
   ptr_t       rd_cnt;
   bit         saw_wrap;
   int         n_chk = 0;
   int         n_err = 0;

   fifo_rd_ctrl #(
      .DATA_WIDTH    (8),
      .ADDR_WIDTH    (3),
      .AEMPTY_THRESH (1)
   ) u_dut (
      .i_rclk     (i_rclk),
      .i_rrst_n   (i_rrst_n),
      .i_rq2_wptr (i_rq2_wptr),
      .o_raddr    (o_raddr),
      .i_rdata    (i_rdata),
      .o_rptr     (o_rptr),
      .o_rempty   (o_rempty),
      .o_raempty  (o_raempty),
      .o_rlevel   (o_rlevel),
      .o_rdata    (o_rdata),
      .o_rvalid   (o_rvalid),
      .i_rready   (i_rready)
   );

   always #5 i_rclk = ~i_rclk;

   assign i_rdata = mem[o_raddr];

   function automatic logic [3:0] to_gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_rclk);
      #1;
   endtask

   task automatic write_words(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wbin[2:0]] = base + 8'(i);
         exp_q.push_back(base + 8'(i));
         wbin = wbin + 4'd1;
      end
      i_rq2_wptr = to_gray(wbin);
   endtask

   task automatic check_reset_values();
      check("rst_rempty",  32'(o_rempty),  32'd1);
      check("rst_raempty", 32'(o_raempty), 32'd1);
      check("rst_rlevel",  32'(o_rlevel),  32'd0);
      check("rst_rvalid",  32'(o_rvalid),  32'd0);
      check("rst_rdata",   32'(o_rdata),   32'd0);
      check("rst_rptr",    32'(o_rptr),    32'd0);
      check("rst_raddr",   32'(o_raddr),   32'd0);
   endtask

   task automatic clear_model();
      wbin       = '0;
      rd_cnt     = '0;
      i_rq2_wptr = '0;
      exp_q.delete();
   endtask

   // mode 0: always ready; mode 1: ready alternates 1,0,1,0...
   task automatic drain(input int n, input int mode);
      int         got;
      int         cyc;
      int         first;
      int         last;
      bit         prev_stall;
      bit         pop_now;
      logic [7:0] prev_d;
      logic [3:0] prev_ptr;
      got = 0; cyc = 0; first = -1; last = -1; prev_stall = 0; prev_d = '0;
      while (got < n && cyc < 200) begin
         i_rready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         if (prev_stall) begin
            check("stall_valid", 32'(o_rvalid), 32'd1);
            check("stall_data",  32'(o_rdata),  32'(prev_d));
         end
         if (o_rvalid && i_rready) begin
            if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
            else check("beat_data", 32'(o_rdata), 32'(exp_q.pop_front()));
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         pop_now = !o_rempty && (!o_rvalid || i_rready);
         if (pop_now) check("pop_addr", 32'(o_raddr), 32'(rd_cnt[2:0]));
         prev_stall = o_rvalid && !i_rready;
         prev_d     = o_rdata;
         prev_ptr   = o_rptr;
         tick();
         cyc++;
         if (pop_now) rd_cnt = rd_cnt + 4'd1;
         check("rptr", 32'(o_rptr), 32'(to_gray(rd_cnt)));
         check("rptr_step", 32'($countones(o_rptr ^ prev_ptr) <= 1), 32'd1);
         if (prev_ptr == 4'b1000 && o_rptr == 4'b0000) saw_wrap = 1'b1;
      end
      if (got < n) check("drain_done", 32'(got), 32'(n));
      i_rready = 1'b0;
      if (mode == 0 && got == n) check("back_to_back", 32'(last - first), 32'(n - 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end before 200000");
      $fatal(1);
   end

   initial begin
      i_rrst_n = 1'b1;
      i_rready = 1'b0;
      saw_wrap = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      clear_model();
      #1 i_rrst_n = 1'b0;
      #2;
      check_reset_values();
      tick();
      tick();
      i_rrst_n = 1'b1;

      // Single word, consumer stalled
      write_words(1, 8'hA5);
      tick();
      check("single_rempty_fall", 32'(o_rempty), 32'd0);
      check("single_rvalid_lat",  32'(o_rvalid), 32'd0);
      tick();
      check("single_rvalid", 32'(o_rvalid), 32'd1);
      check("single_rdata",  32'(o_rdata),  32'hA5);
      check("single_rptr",   32'(o_rptr),   32'b0001);
      check("single_rempty", 32'(o_rempty), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("single_hold_data",  32'(o_rdata),  32'hA5);
         check("single_hold_valid", 32'(o_rvalid), 32'd1);
      end

      // Asynchronous reset with a word in the output stage
      i_rrst_n = 1'b0;
      #2;
      check_reset_values();
      clear_model();
      tick();
      i_rrst_n = 1'b1;

      // Stream of 8 words from address 0
      write_words(8, 8'h10);
      drain(8, 0);
      check("stream_rptr",   32'(o_rptr),   32'b1100);
      check("stream_rempty", 32'(o_rempty), 32'd1);

      // Full memory, then drain under backpressure
      write_words(8, 8'h40);
      tick();
      check("full_rlevel",  32'(o_rlevel),  32'd8);
      check("full_rempty",  32'(o_rempty),  32'd0);
      check("full_raempty", 32'(o_raempty), 32'd0);
      drain(8, 1);
      check("bp_rempty", 32'(o_rempty), 32'd1);

      // Wrap: 20 words in bursts of 5
      saw_wrap = 1'b0;
      for (int k = 0; k < 4; k++) begin
         write_words(5, 8'h80 + 8'(5 * k));
         drain(5, 0);
      end
      check("wrap_seen", 32'(saw_wrap), 32'd1);
      check("wrap_empty_q", 32'(exp_q.size()), 32'd0);

      // Level and almost-empty
      tick();
      i_rrst_n = 1'b0;
      #2;
      clear_model();
      tick();
      i_rrst_n = 1'b1;
      write_words(5, 8'hC0);
      check("lvl_wptr", 32'(i_rq2_wptr), 32'b0111);
      tick();
      tick();
      check("lvl_rlevel4",  32'(o_rlevel),  32'd4);
      check("lvl_raempty0", 32'(o_raempty), 32'd0);
      check("lvl_rvalid",   32'(o_rvalid),  32'd1);
      i_rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("lvl_beat", 32'(o_rdata), 32'(exp_q.pop_front()));
         tick();
         check("lvl_rlevel", 32'(o_rlevel), 32'(3 - i));
      end
      i_rready = 1'b0;
      check("lvl_rlevel1",  32'(o_rlevel),  32'd1);
      check("lvl_raempty1", 32'(o_raempty), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
